led_display_arbiter: RTL and testbench
======================================

LED_DISPLAY_ARBITER -- requirements
Module: led_display_arbiter

Interface
REQ-001 Parameter LED_WIDTH, default 8: width of each LED pattern and of led_data.
REQ-002 Parameter HOLD_TOP, default 24'h3F_FFFF: minimum-hold terminal count; 24-bit; legal range 1..24'hFF_FFFF.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  3  per-requester display request; bit 0 = requester 0.
REQ-006 req_data  input  3*LED_WIDTH  patterns, requester k at bits [k*LED_WIDTH +: LED_WIDTH].
REQ-007 grant  output  3  registered one-hot grant, or 3'b000 when idle.
REQ-008 led_data  output  LED_WIDTH  registered LED drive.
REQ-009 busy  output  1  registered; 1 while in HOLD.

Function
REQ-010 The block SHALL implement two states, IDLE and HOLD, with a 24-bit hold_cnt and a 2-bit last-winner index last_idx.
REQ-011 In IDLE, on any edge where req != 0, the block SHALL load grant with the winner, load led_data with the winner's pattern, clear hold_cnt, set last_idx to the winner, and enter HOLD; with req == 0 it SHALL stay in IDLE and hold grant = 0, led_data = 0.
REQ-012 In HOLD, led_data SHALL follow the granted requester's req_data with exactly one cycle of latency.
REQ-013 In HOLD, hold_cnt SHALL increment by 1 per cycle and saturate at HOLD_TOP, with no wrap-around.
REQ-014 In HOLD, if the granted bit of req is 0 at an edge, the next state SHALL be IDLE with grant = 0 and led_data = 0, regardless of hold_cnt (abort).
REQ-015 In HOLD, the block SHALL re-arbitrate only when hold_cnt == HOLD_TOP, the holder still requests, and at least one other req bit is 1.
REQ-016 On re-arbitration, the block SHALL switch grant directly to the new winner on that edge with no IDLE cycle, load the new winner's pattern, clear hold_cnt, and update last_idx.
REQ-017 If re-arbitration selects the current holder, grant SHALL remain unchanged and hold_cnt SHALL remain at HOLD_TOP.
REQ-018 When the holder's drop coincides with other requests, the drop SHALL take precedence: one IDLE cycle with grant = 0 and led_data = 0, then normal IDLE arbitration.
REQ-019 grant SHALL never have more than one bit set.
REQ-020 busy SHALL be 1 exactly when the state is HOLD.

Reset
REQ-021 When rst_n is low, the block SHALL asynchronously force state = IDLE, grant = 0, led_data = 0, busy = 0, hold_cnt = 0 and last_idx = 2, including in the middle of a hold.
REQ-022 The first arbitration after reset release SHALL occur on the first rising edge with rst_n high and req != 0.

Configuration
REQ-023 With macro LED_ARB_ROUND_ROBIN_EN undefined, arbitration SHALL be fixed priority (req[0] > req[1] > req[2]) and the holder SHALL compete at its own fixed rank.
REQ-024 With LED_ARB_ROUND_ROBIN_EN defined, priority SHALL rotate starting at (last_idx+1) mod 3, so the current holder has lowest priority; after reset this makes requester 0 highest.

Verification (HOLD_TOP = 3)
REQ-025 Reset: rst_n low asynchronously mid-cycle -> grant = 000, led_data = 00 and busy = 0 immediately, before the next clock edge.
REQ-026 Single request: req = 010 with pattern 1 = 8'h5A -> grant = 010, led_data = 5A and busy = 1 at the first edge; pattern 1 changed to 8'hA5 -> led_data = A5 one cycle later.
REQ-027 Fixed priority (macro undefined): req = 011 held for 20 cycles -> grant stays at 001 for all 20 cycles; requester 1 is never granted.
REQ-028 Round-robin (macro defined): req = 011 held -> grant = 001 at edge 1 and 010 at edge 5, then alternates every 4 cycles; led_data tracks the corresponding pattern each time.
REQ-029 Abort: req = 100, then req[2] dropped when hold_cnt = 1 -> next edge grant = 000, led_data = 00, busy = 0; no switch to another requester occurs on that edge.
REQ-030 Drop with others pending: holder 001 drops while req = 110 -> one cycle with grant = 000, then grant = 010 (fixed priority) on the following edge.

Source files
------------

// File: rtl/led_display_arbiter.sv
// Three-requester LED display arbiter with a minimum-hold timer.
// Define LED_ARB_ROUND_ROBIN_EN for rotating priority; otherwise priority is fixed (0 > 1 > 2).
module led_display_arbiter #(
  parameter int          LED_WIDTH = 8,
  parameter logic [23:0] HOLD_TOP  = 24'h3F_FFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             req,
  input  logic [3*LED_WIDTH-1:0] req_data,
  output logic [2:0]             grant,
  output logic [LED_WIDTH-1:0]   led_data,
  output logic                   busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             grant_q, grant_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;
  logic [23:0]            cnt_q, cnt_d;
  logic [1:0]             last_q, last_d;
  logic                   busy_q, busy_d;
  logic [1:0]             win;
  logic [1:0]             hold_idx;

  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] w;
    w = 2'd0;
`ifdef LED_ARB_ROUND_ROBIN_EN
    // Search starts just after the last winner, so the holder ranks lowest.
    case (last)
      2'd0:    w = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd1:    w = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: w = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
`else
    w = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    if (last == 2'd3) w = 2'd0;
`endif
    return w;
  endfunction

  function automatic logic [LED_WIDTH-1:0] sel_pat(input logic [3*LED_WIDTH-1:0] d,
                                                   input logic [1:0] idx);
    case (idx)
      2'd0:    return d[0 +: LED_WIDTH];
      2'd1:    return d[LED_WIDTH +: LED_WIDTH];
      default: return d[2*LED_WIDTH +: LED_WIDTH];
    endcase
  endfunction

  assign win      = pick(req, last_q);
  assign hold_idx = grant_q[1] ? 2'd1 : (grant_q[2] ? 2'd2 : 2'd0);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      grant_d = 3'b000;
      led_d   = '0;
      if (req != 3'b000) begin
        state_d = HOLD;
        grant_d = 3'b001 << win;
        led_d   = sel_pat(req_data, win);
        cnt_d   = 24'd0;
        last_d  = win;
      end
    end else if (!req[hold_idx]) begin
      // A holder drop wins over any pending request: one full IDLE cycle follows.
      state_d = IDLE;
      grant_d = 3'b000;
      led_d   = '0;
      cnt_d   = 24'd0;
    end else if (cnt_q == HOLD_TOP && (req & ~grant_q) != 3'b000 && win != hold_idx) begin
      grant_d = 3'b001 << win;
      led_d   = sel_pat(req_data, win);
      cnt_d   = 24'd0;
      last_d  = win;
    end else begin
      led_d = sel_pat(req_data, hold_idx);
      if (cnt_q != HOLD_TOP) cnt_d = cnt_q + 24'd1;
    end
    busy_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      led_q   <= '0;
      cnt_q   <= 24'd0;
      last_q  <= 2'd2;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign led_data = led_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Bench for led_display_arbiter (HOLD_TOP = 3): directed scenarios then random traffic
// against a behavioural model of holder / hold count / last winner.
module tb_led_display_arbiter;

  localparam int HT = 3;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  grant;
  logic [7:0]  led_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] pat [3];
  int m_holder;
  int m_cnt;
  int m_last;
  logic [7:0] m_led;

  led_display_arbiter #(.LED_WIDTH(8), .HOLD_TOP(24'd3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .led_data(led_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_arb(input logic [2:0] r, input int last);
    int start;
`ifdef LED_ARB_ROUND_ROBIN_EN
    start = (last + 1) % 3;
`else
    start = 0;
`endif
    for (int k = 0; k < 3; k++)
      if (r[(start + k) % 3]) return (start + k) % 3;
    return -1;
  endfunction

  task automatic m_reset();
    m_holder = -1;
    m_cnt    = 0;
    m_last   = 2;
    m_led    = 8'h00;
  endtask

  task automatic m_update(input logic [2:0] r);
    int w;
    int others;
    if (m_holder < 0) begin
      w = m_arb(r, m_last);
      if (w >= 0) begin
        m_holder = w; m_cnt = 0; m_last = w; m_led = pat[w];
      end else m_led = 8'h00;
    end else if (!r[m_holder]) begin
      m_holder = -1; m_cnt = 0; m_led = 8'h00;
    end else begin
      others = 0;
      for (int k = 0; k < 3; k++) if (k != m_holder && r[k]) others = 1;
      w = m_arb(r, m_last);
      if (m_cnt == HT && others == 1 && w != m_holder) begin
        m_holder = w; m_cnt = 0; m_last = w;
      end else if (m_cnt < HT) m_cnt = m_cnt + 1;
      m_led = pat[m_holder];
    end
  endtask

  task automatic check_model(input string tag);
    logic [2:0] eg;
    eg = (m_holder < 0) ? 3'b000 : 3'(1 << m_holder);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".led"},   32'(led_data), 32'(m_led));
    chk({tag, ".busy"},  32'(busy), 32'(m_holder >= 0));
    chk({tag, ".onehot"}, 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic step(input logic [2:0] r, input string tag);
    @(negedge clk);
    req      = r;
    req_data = {pat[2], pat[1], pat[0]};
    @(posedge clk);
    m_update(r);
    #1;
    check_model(tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, ".grant"}, 32'(grant), 32'd0);
    chk({tag, ".led"},   32'(led_data), 32'd0);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    m_reset();
    @(negedge clk);
    req   = 3'b000;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] r;
    logic [2:0] exp_g;
    rst_n = 1'b0;
    req = 3'b000;
    req_data = '0;
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
    m_reset();
    #2;
    chk("por.grant", 32'(grant), 32'd0);
    chk("por.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(3'b000, "idle");

    // Single request, then one-cycle pattern tracking.
    pat[1] = 8'h5A;
    step(3'b010, "single1");
    chk("single1.led_const", 32'(led_data), 32'h5A);
    pat[1] = 8'hA5;
    step(3'b010, "single2");
    chk("single2.led_const", 32'(led_data), 32'hA5);
    // Reset in the middle of a hold.
    step(3'b010, "single3");
    async_reset("midreset");

    // Two contenders held for 20 cycles.
    pat[0] = 8'hC0; pat[1] = 8'h0C;
    for (int i = 0; i < 20; i++) begin
      step(3'b011, "contend");
`ifdef LED_ARB_ROUND_ROBIN_EN
      exp_g = (((i / 4) % 2) == 0) ? 3'b001 : 3'b010;
`else
      exp_g = 3'b001;
`endif
      chk("contend.grant_const", 32'(grant), 32'(exp_g));
    end
    step(3'b000, "contend_end");
    step(3'b000, "idle2");

    // Abort when hold_cnt = 1; others pending must not be granted on that edge.
    step(3'b100, "abort0");
    step(3'b100, "abort1");
    step(3'b011, "abort_drop");
    chk("abort_drop.grant_const", 32'(grant), 32'd0);
    chk("abort_drop.busy_const", 32'(busy), 32'd0);
    step(3'b011, "abort_next");
    step(3'b000, "idle3");

    // Holder 0 drops while 1 and 2 request.
    step(3'b001, "drop0");
    step(3'b110, "drop1");
    chk("drop1.grant_const", 32'(grant), 32'd0);
    step(3'b110, "drop2");
    chk("drop2.grant_const", 32'(grant), 32'b010);
    step(3'b000, "idle4");

    // Random traffic with sticky requests so holds reach the terminal count.
    r = 3'b000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 6) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 3) == 0) pat[$urandom_range(0, 2)] = 8'($urandom);
      step(r, "rand");
      if (i == 200) async_reset("randreset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
